id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection.
//  - Captures decoded operands and control from the ID stage.
//  - Presents them to the EX stage, i.e. to the operand forwarding logic
//    and the ALU.
//  - Detects a load followed by a dependent instruction, stalls the front
//    end, and inserts one bubble.
//  - Counts stall and flush events for performance monitoring.

---
 rtl/id_ex_pipe_reg.sv | 125 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction for the EX stage. It stalls the front end and
// inserts a single bubble when a load in EX feeds the instruction in ID. It
// also counts the load-use bubbles and the flushes it applies.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              id_mem_read_i,
  input  logic [XLEN-1:0]   id_reg1_i,
  input  logic [XLEN-1:0]   id_reg2_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_mem_read_o,
  output logic [XLEN-1:0]   ex_reg1_o,
  output logic [XLEN-1:0]   ex_reg2_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // The complete EX slot. A bubble is this struct with every field cleared.
  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              mem_read;
    logic [XLEN-1:0]   reg1;
    logic [XLEN-1:0]   reg2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } ex_slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_slot_t         ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_s;

  // Load-use hazard: a load in EX whose non-x0 rd is read by the valid ID instruction
  always_comb begin
    lu_s = id_valid_i & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0)
         & ((id_uses_rs1_i & (id_rs1_i == ex_q.rd))
          | (id_uses_rs2_i & (id_rs2_i == ex_q.rd)));
    // Flush kills the dependent instruction anyway, and hold freezes everything.
    stall_o = lu_s & ~flush_i & ~hold_i;
  end

  // Next-state selection, highest priority first: flush, hold, load-use bubble, capture
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i) begin
      ex_d        = '0;
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (hold_i) begin
      ex_d        = ex_q;
    end else if (lu_s) begin
      ex_d        = '0;
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      ex_d.valid    = id_valid_i;
      ex_d.rs1      = id_rs1_i;
      ex_d.rs2      = id_rs2_i;
      // An invalid slot must never write a register, touch memory or drive control.
      ex_d.rd       = id_valid_i ? id_rd_i : 5'd0;
      ex_d.mem_read = id_valid_i & id_mem_read_i;
      ex_d.ctrl     = id_valid_i ? id_ctrl_i : {CTRL_W{1'b0}};
      ex_d.reg1     = id_reg1_i;
      ex_d.reg2     = id_reg2_i;
      ex_d.imm      = id_imm_i;
      ex_d.pc       = id_pc_i;
    end
  end

  // EX slot and event counters; reset drops any in-flight instruction
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_q        <= '0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_mem_read_o = ex_q.mem_read;
  assign ex_reg1_o     = ex_q.reg1;
  assign ex_reg2_o     = ex_q.reg2;
  assign ex_imm_o      = ex_q.imm;
  assign ex_pc_o       = ex_q.pc;
  assign ex_ctrl_o     = ex_q.ctrl;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench for the ID/EX pipeline register.
// Every step pushes the expected EX state. The entry is popped and compared
// after the clock edge. The counters are 4 bits wide, so the wrap case is reached quickly.
module tb_id_ex_pipe_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              id_valid_i;
  logic [4:0]        id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_uses_rs1_i, id_uses_rs2_i, id_mem_read_i;
  logic [XLEN-1:0]   id_reg1_i, id_reg2_i, id_imm_i, id_pc_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              hold_i, flush_i;
  logic              ex_valid_o, ex_mem_read_o, stall_o;
  logic [4:0]        ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [XLEN-1:0]   ex_reg1_o, ex_reg2_o, ex_imm_o, ex_pc_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1, rs2, rd;
    logic              mem_read;
    logic [XLEN-1:0]   reg1, reg2, imm, pc;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  scnt, fcnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  id_ex_pipe_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_mem_read_i(id_mem_read_i), .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i), .id_ctrl_i(id_ctrl_i),
    .hold_i(hold_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o), .ex_ctrl_o(ex_ctrl_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // 10 time-unit clock
  always #5 clk_i = ~clk_i;

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic mr, input logic [XLEN-1:0] r1,
                        input logic [XLEN-1:0] r2, input logic [CTRL_W-1:0] ctrl);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_mem_read_i = mr;
    id_reg1_i = r1; id_reg2_i = r2; id_ctrl_i = ctrl;
    id_imm_i = r1 ^ 32'h0000_0F00; id_pc_i = {16'h0000, 8'h10, 3'b000, rd, 2'b00} ^ r2;
  endtask

  task automatic compare_all(input exp_t e);
    check_eq("ex_valid",    {63'd0, ex_valid_o},    {63'd0, e.valid});
    check_eq("ex_rs1",      {59'd0, ex_rs1_o},      {59'd0, e.rs1});
    check_eq("ex_rs2",      {59'd0, ex_rs2_o},      {59'd0, e.rs2});
    check_eq("ex_rd",       {59'd0, ex_rd_o},       {59'd0, e.rd});
    check_eq("ex_mem_read", {63'd0, ex_mem_read_o}, {63'd0, e.mem_read});
    check_eq("ex_reg1",     {32'd0, ex_reg1_o},     {32'd0, e.reg1});
    check_eq("ex_reg2",     {32'd0, ex_reg2_o},     {32'd0, e.reg2});
    check_eq("ex_imm",      {32'd0, ex_imm_o},      {32'd0, e.imm});
    check_eq("ex_pc",       {32'd0, ex_pc_o},       {32'd0, e.pc});
    check_eq("ex_ctrl",     {56'd0, ex_ctrl_o},     {56'd0, e.ctrl});
    check_eq("stall_cnt",   {60'd0, stall_cnt_o},   {60'd0, e.scnt});
    check_eq("flush_cnt",   {60'd0, flush_cnt_o},   {60'd0, e.fcnt});
  endtask

  // One clock: check stall_o, push the predicted state, clock, pop and compare
  task automatic step();
    exp_t nx, e;
    logic lu, st;
    #1;
    lu = id_valid_i & m.valid & m.mem_read & (m.rd != 5'd0)
       & ((id_uses_rs1_i & (id_rs1_i == m.rd)) | (id_uses_rs2_i & (id_rs2_i == m.rd)));
    st = lu & ~flush_i & ~hold_i;
    check_eq("stall_o", {63'd0, stall_o}, {63'd0, st});
    nx = m;
    if (flush_i) begin
      nx = '0; nx.scnt = m.scnt; nx.fcnt = m.fcnt + 4'd1;
    end else if (hold_i) begin
      nx = m;
    end else if (lu) begin
      nx = '0; nx.fcnt = m.fcnt; nx.scnt = m.scnt + 4'd1;
    end else begin
      nx.valid = id_valid_i; nx.rs1 = id_rs1_i; nx.rs2 = id_rs2_i;
      nx.rd = id_valid_i ? id_rd_i : 5'd0;
      nx.mem_read = id_valid_i & id_mem_read_i;
      nx.ctrl = id_valid_i ? id_ctrl_i : 8'h00;
      nx.reg1 = id_reg1_i; nx.reg2 = id_reg2_i; nx.imm = id_imm_i; nx.pc = id_pc_i;
    end
    sb_q.push_back(nx);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      compare_all(e);
      m = e;
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once
  task automatic pulse_reset();
    #1;
    reset_i = 1'b1;
    #1;
    m = '0;
    compare_all(m);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'h00);
    m = '0;
    repeat (2) @(posedge clk_i);
    #1;
    compare_all(m);
    #2;
    reset_i = 1'b0;

    // Normal flow: add x3, x1, x2
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 8'hA5);
    step();
    check_eq("add_rd", {59'd0, ex_rd_o}, 64'd3);
    check_eq("add_reg1", {32'd0, ex_reg1_o}, 64'd5);
    check_eq("add_reg2", {32'd0, ex_reg2_o}, 64'd7);

    // Invalid ID slot: rd/ctrl/mem_read forced to zero
    set_id(1'b0, 5'd4, 5'd6, 5'd9, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 8'hFF);
    step();
    check_eq("inv_rd", {59'd0, ex_rd_o}, 64'd0);

    // Load-use: lw x5, then add x6 reading x5
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 8'h03);
    step();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h9, 32'h4, 8'h21);
    #1;
    check_eq("lu_stall", {63'd0, stall_o}, 64'd1);
    step();
    check_eq("lu_bubble", {63'd0, ex_valid_o}, 64'd0);
    check_eq("lu_scnt", {60'd0, stall_cnt_o}, 64'd1);
    step();
    check_eq("lu_capture_rd", {59'd0, ex_rd_o}, 64'd6);

    // lw x0 never creates a hazard
    set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 8'h03);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h1, 32'h2, 8'h10);
    #1;
    check_eq("x0_stall", {63'd0, stall_o}, 64'd0);
    step();

    // Unused rs2 matching the load's rd does not stall
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 8'h03);
    step();
    set_id(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0, 32'h3, 32'h4, 8'h11);
    #1;
    check_eq("unused_rs2_stall", {63'd0, stall_o}, 64'd0);
    step();

    // Mid-cycle reset with a valid instruction in EX
    check_eq("pre_reset_valid", {63'd0, ex_valid_o}, 64'd1);
    pulse_reset();

    // Flush overrides a load-use condition
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 8'h03);
    step();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h9, 32'h4, 8'h21);
    flush_i = 1'b1;
    #1;
    check_eq("flush_stall", {63'd0, stall_o}, 64'd0);
    step();
    flush_i = 1'b0;
    check_eq("flush_fcnt", {60'd0, flush_cnt_o}, 64'd1);
    check_eq("flush_scnt", {60'd0, stall_cnt_o}, 64'd0);
    check_eq("flush_valid", {63'd0, ex_valid_o}, 64'd0);

    // Hold freezes EX for three cycles even with a load-use condition present
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 8'h03);
    step();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h9, 32'h4, 8'h21);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_rd", {59'd0, ex_rd_o}, 64'd5);
      check_eq("hold_reg1", {32'd0, ex_reg1_o}, 64'h500);
    end
    hold_i = 1'b0;
    step();
    check_eq("post_hold_scnt", {60'd0, stall_cnt_o}, 64'd1);

    // Counter wrap: 16 load-use bubbles on a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'(i), 32'h0, 8'h03);
      step();
      set_id(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 32'h1, 32'(i), 8'h21);
      step();
      if (i == 14) check_eq("wrap_15", {60'd0, stall_cnt_o}, 64'd15);
    end
    check_eq("wrap_0", {60'd0, stall_cnt_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
